// File: rtl/id_ex_skid_if.sv
// Handshake and beat signals between the ID stage, the ID/EX skid register and the ALU.
// The slave modport is the register's view; the master modport is the driving environment.
interface id_ex_skid_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [3:0]  ctrl_i;
    logic [4:0]  rd_i;
    logic        we_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] src1_o;
    logic [31:0] src2_o;
    logic [3:0]  ctrl_o;
    logic [4:0]  rd_o;
    logic        we_o;
    logic [1:0]  count_o;
    logic        illegal_o;

    modport slave (
        input  in_valid_i, src1_i, src2_i, ctrl_i, rd_i, we_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, rd_o, we_o, count_o, illegal_o
    );

    modport master (
        output in_valid_i, src1_i, src2_i, ctrl_i, rd_i, we_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, rd_o, we_o, count_o, illegal_o
    );
endinterface

// File: rtl/id_ex_skid_reg.sv
// Two-entry ID/EX skid buffer: main entry drives the ALU, skid entry absorbs one beat of
// overflow so in_ready_o can be a plain register, independent of out_ready_i.
module id_ex_skid_reg (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_skid_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
    } beat_t;

    state_e state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   illegal_q, illegal_d;

    beat_t  in_beat;
    logic   ctrl_legal;
    logic   accept;
    logic   deliver;

    // Illegal control codes are neutralised on entry so the ALU never sees them.
    always_comb begin
        ctrl_legal = 1'b0;
        case (bus.ctrl_i)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7: ctrl_legal = 1'b1;
            default:                      ctrl_legal = 1'b0;
        endcase

        in_beat.src1 = bus.src1_i;
        in_beat.src2 = bus.src2_i;
        in_beat.rd   = bus.rd_i;
        in_beat.ctrl = ctrl_legal ? bus.ctrl_i : 4'd0;
        in_beat.we   = ctrl_legal ? bus.we_i   : 1'b0;
    end

    assign accept  = bus.in_valid_i && in_ready_q && !bus.flush_i;
    assign deliver = (state_q != EMPTY) && bus.out_ready_i;

    // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        illegal_d = illegal_q | (accept & ~ctrl_legal);

        if (bus.flush_i) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_beat;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_d = in_beat;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_beat;
                    end else if (deliver) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    // in_ready_o is low here, so only the head can leave.
                    if (deliver) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end

        in_ready_d = (state_d != FULL);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = (state_q != EMPTY);
    assign bus.count_o     = state_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.src1_o      = main_q.src1;
    assign bus.src2_o      = main_q.src2;
    assign bus.ctrl_o      = main_q.ctrl;
    assign bus.rd_o        = main_q.rd;
    assign bus.we_o        = main_q.we;

endmodule
